// File: rtl/fp_pkg.sv
// Shared FP rounding types: format/rounding-mode encodings, default NaN and
// the request payload handed from the execution units to the rounder.
package fp_pkg;

  localparam logic [1:0] FMT_SNG = 2'd0;
  localparam logic [1:0] FMT_DBL = 2'd1;
  localparam logic [1:0] FMT_EXT = 2'd2;
  localparam logic [1:0] FMT_ILL = 2'd3;

  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;

  // Tag field is sized for the widest writeback tag any instance may carry.
  localparam int unsigned RND_TAG_W = 16;

  localparam logic [79:0] DEFAULT_NAN_EXT = 80'h7FFF_C000_0000_0000_0000;

  typedef struct packed {
    logic [80:0]          a;
    logic                 rbit;
    logic                 tail;
    logic                 rndbit;
    logic [2:0]           rmode;
    logic [1:0]           fmt_in;
    logic [1:0]           fmt_out;
    logic [RND_TAG_W-1:0] tag;
  } rnd_req_t;

endpackage

// File: rtl/fprnd.sv
// Rounds an unrounded sign/exponent/65-bit mantissa to the narrower of the
// source and destination precisions, renormalising on mantissa carry-out.
module fprnd
  import fp_pkg::*;
(
  input  logic [80:0] A,
  input  logic        rbit,
  input  logic        tail,
  input  logic        rndbit,
  input  logic [2:0]  rmode,
  input  logic        isDBL,
  input  logic        isEXT,
  input  logic        toDBL,
  input  logic        toSNG,
  output logic [79:0] B
);

  logic        sign;
  logic [14:0] exp_in;
  logic [64:0] mant_in;
  logic        prec_sng;
  logic        prec_dbl;
  logic        inc;
  logic [64:0] ulp;
  logic [64:0] keep_mask;
  logic [65:0] sum;
  logic [63:0] mant_out;
  logic [14:0] exp_out;

  always_comb begin
    sign     = A[80];
    exp_in   = A[79:65];
    mant_in  = A[64:0];
    prec_sng = toSNG | (!isDBL & !isEXT);
    prec_dbl = !prec_sng & (toDBL | isDBL);

    // Unit in the last place of a 24/53/64-bit significand inside 64 bits.
    if (prec_sng) begin
      ulp = 65'd1 << 40;
    end else if (prec_dbl) begin
      ulp = 65'd1 << 11;
    end else begin
      ulp = 65'd1;
    end
    keep_mask = ~(ulp - 65'd1);

    case (rmode)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = sign & (rbit | tail);
      RM_RUP:  inc = !sign & (rbit | tail);
      RM_RMM:  inc = rbit;
      default: inc = rbit & (tail | rndbit);
    endcase

    sum = {1'b0, mant_in & keep_mask} + (inc ? {1'b0, ulp} : 66'd0);

    if (sum[65]) begin
      mant_out = sum[65:2];
      exp_out  = exp_in + 15'd2;
    end else if (sum[64]) begin
      mant_out = sum[64:1];
      exp_out  = exp_in + 15'd1;
    end else begin
      mant_out = sum[63:0];
      exp_out  = exp_in;
    end

    B = {sign, exp_out, mant_out};
  end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; ptr holds the last granted index and only
// moves when a grant is issued (grants are only given to valid requesters).
module rr_arb2 #(
  parameter bit RST_PTR = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] vld,
  output logic [1:0] gnt
);

  logic ptr;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (vld)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = ptr ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= RST_PTR;
    end else if (|gnt) begin
      ptr <= gnt[1];
    end
  end

endmodule

// File: rtl/fprnd_sched.sv
// Shares one fprnd rounder between the FADD (req 0) and FMUL (req 1) result
// paths through a two-stage valid/ready pipeline with round-robin arbitration.
module fprnd_sched
  import fp_pkg::*;
#(
  parameter int unsigned TAG_W   = 9,
  parameter bit          RST_PTR = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [1:0]            req_vld,
  output logic [1:0]            req_rdy,
  input  logic [1:0][80:0]      req_A,
  input  logic [1:0]            req_rbit,
  input  logic [1:0]            req_tail,
  input  logic [1:0]            req_rndbit,
  input  logic [1:0][2:0]       req_rmode,
  input  logic [1:0][1:0]       req_fmt_in,
  input  logic [1:0][1:0]       req_fmt_out,
  input  logic [1:0][TAG_W-1:0] req_tag,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [79:0]           out_res,
  output logic [TAG_W-1:0]      out_tag,
  output logic                  out_src,
  output logic                  out_inv
);

  logic       s1_vld;
  logic       s1_src;
  rnd_req_t   s1_req;
  logic       s2_vld;
  logic       s1_adv;
  logic       s2_adv;
  logic       arb_en;
  logic [1:0] gnt;
  logic       xfer;
  logic       sel_src;
  rnd_req_t   sel_req;
  logic       s1_inv;
  logic [79:0] rnd_b;

  assign s2_adv  = !s2_vld | out_rdy;
  assign s1_adv  = !s1_vld | s2_adv;
  // No grant while in reset or flushing, so flush wins over a new request.
  assign arb_en  = s1_adv & !flush & rst_n;
  assign req_rdy = gnt;
  assign xfer    = |gnt;
  assign sel_src = gnt[1];
  assign out_vld = s2_vld;

  rr_arb2 #(
    .RST_PTR (RST_PTR)
  ) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (arb_en),
    .vld   (req_vld),
    .gnt   (gnt)
  );

  always_comb begin
    sel_req         = '0;
    sel_req.a       = req_A[sel_src];
    sel_req.rbit    = req_rbit[sel_src];
    sel_req.tail    = req_tail[sel_src];
    sel_req.rndbit  = req_rndbit[sel_src];
    sel_req.rmode   = req_rmode[sel_src];
    sel_req.fmt_in  = req_fmt_in[sel_src];
    sel_req.fmt_out = req_fmt_out[sel_src];
    sel_req.tag     = RND_TAG_W'(req_tag[sel_src]);
  end

  // Operand stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_src <= 1'b0;
      s1_req <= '0;
    end else begin
      if (flush) begin
        s1_vld <= 1'b0;
      end else if (s1_adv) begin
        s1_vld <= xfer;
      end
      if (xfer) begin
        s1_req <= sel_req;
        s1_src <= sel_src;
      end
    end
  end

  assign s1_inv = (s1_req.fmt_in == FMT_ILL) | (s1_req.fmt_out == FMT_ILL);

  fprnd u_rnd (
    .A      (s1_req.a),
    .rbit   (s1_req.rbit),
    .tail   (s1_req.tail),
    .rndbit (s1_req.rndbit),
    .rmode  (s1_req.rmode),
    .isDBL  (s1_req.fmt_in == FMT_DBL),
    .isEXT  (s1_req.fmt_in == FMT_EXT),
    .toDBL  (s1_req.fmt_out == FMT_DBL),
    .toSNG  (s1_req.fmt_out == FMT_SNG),
    .B      (rnd_b)
  );

  // Result stage; holds everything while the writeback stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_vld  <= 1'b0;
      out_res <= '0;
      out_tag <= '0;
      out_src <= 1'b0;
      out_inv <= 1'b0;
    end else begin
      if (flush) begin
        s2_vld <= 1'b0;
      end else if (s2_adv) begin
        s2_vld <= s1_vld;
      end
      if (s2_adv) begin
        out_res <= s1_inv ? DEFAULT_NAN_EXT : rnd_b;
        out_tag <= TAG_W'(s1_req.tag);
        out_src <= s1_src;
        out_inv <= s1_inv;
      end
    end
  end

endmodule

// File: tb/tb_fprnd_sched.sv
// Scenario bench for fprnd_sched: per-feature tasks with inline checks plus a
// scoreboard fed at each accepted request and drained at each consumed result.
module tb_fprnd_sched;

  localparam int unsigned TW = 9;

  typedef struct packed {
    logic [79:0]   res;
    logic [TW-1:0] tag;
    logic          src;
    logic          inv;
  } exp_t;

  logic                clk;
  logic                rst_n;
  logic                flush;
  logic [1:0]          req_vld;
  logic [1:0]          req_rdy;
  logic [1:0][80:0]    req_A;
  logic [1:0]          req_rbit;
  logic [1:0]          req_tail;
  logic [1:0]          req_rndbit;
  logic [1:0][2:0]     req_rmode;
  logic [1:0][1:0]     req_fmt_in;
  logic [1:0][1:0]     req_fmt_out;
  logic [1:0][TW-1:0]  req_tag;
  logic                out_vld;
  logic                out_rdy;
  logic [79:0]         out_res;
  logic [TW-1:0]       out_tag;
  logic                out_src;
  logic                out_inv;

  exp_t        sb_q[$];
  logic [9:0]  log_q[$];
  int          t_chk = 0;
  int          t_pass = 0;
  int          sb_chk = 0;
  int          sb_pass = 0;

  fprnd_sched #(.TAG_W(TW), .RST_PTR(1'b1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .req_vld     (req_vld),
    .req_rdy     (req_rdy),
    .req_A       (req_A),
    .req_rbit    (req_rbit),
    .req_tail    (req_tail),
    .req_rndbit  (req_rndbit),
    .req_rmode   (req_rmode),
    .req_fmt_in  (req_fmt_in),
    .req_fmt_out (req_fmt_out),
    .req_tag     (req_tag),
    .out_vld     (out_vld),
    .out_rdy     (out_rdy),
    .out_res     (out_res),
    .out_tag     (out_tag),
    .out_src     (out_src),
    .out_inv     (out_inv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference rounder: truncate to the effective precision, add one ulp if
  // the mode says so, then shift right until the mantissa fits again.
  function automatic logic [79:0] ref_round(logic [80:0] a, logic rb, logic tl, logic lb,
                                            logic [2:0] rm, logic [1:0] fi, logic [1:0] fo);
    int          lsb;
    logic [65:0] m;
    logic [14:0] e;
    logic        up;
    if (fi == 2'd3 || fo == 2'd3) return 80'h7FFF_C000_0000_0000_0000;
    if (fo == 2'd0 || fi == 2'd0 || fi == 2'd3) lsb = 40;
    else if (fo == 2'd1 || fi == 2'd1) lsb = 11;
    else lsb = 0;
    case (rm)
      3'd1:    up = 1'b0;
      3'd2:    up = a[80] & (rb | tl);
      3'd3:    up = !a[80] & (rb | tl);
      3'd4:    up = rb;
      default: up = rb & (tl | lb);
    endcase
    m = {1'b0, a[64:0]};
    m = (m >> lsb) << lsb;
    if (up) m = m + (66'd1 << lsb);
    e = a[79:65];
    while (m[65:64] != 2'b00) begin
      m = m >> 1;
      e = e + 15'd1;
    end
    return {a[80], e, m[63:0]};
  endfunction

  function automatic logic [80:0] mk_a(int t);
    logic [31:0] h;
    h = 32'(t) * 32'h9E37_79B9;
    return {1'(t >> 3), 15'(16'h3F00 + 16'(t)), 1'b0, h, ~h};
  endfunction

  function automatic logic [2:0] mk_rm(int t);
    return 3'((t * 5) >> 1);
  endfunction

  function automatic logic [1:0] mk_fi(int t);
    return 2'(t % 3);
  endfunction

  function automatic logic [1:0] mk_fo(int t);
    return 2'((t / 3) % 3);
  endfunction

  function automatic logic [79:0] ref_tag(int t);
    return ref_round(mk_a(t), t[0], t[1], t[2], mk_rm(t), mk_fi(t), mk_fo(t));
  endfunction

  task automatic set_req(int i, int t);
    req_A[i]       = mk_a(t);
    req_rbit[i]    = t[0];
    req_tail[i]    = t[1];
    req_rndbit[i]  = t[2];
    req_rmode[i]   = mk_rm(t);
    req_fmt_in[i]  = mk_fi(t);
    req_fmt_out[i] = mk_fo(t);
    req_tag[i]     = TW'(t);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (sb_q.size() == 0 && !out_vld) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Scoreboard: looks at what will happen at the coming rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      if (out_vld && out_rdy) begin
        sb_chk++;
        if (sb_q.size() == 0) begin
          $display("FAIL sb_unexpected: tag=%0d src=%0d with nothing outstanding", out_tag, out_src);
        end else begin
          e = sb_q.pop_front();
          if (out_res !== e.res || out_tag !== e.tag || out_src !== e.src || out_inv !== e.inv)
            $display("FAIL sb_result: got res=%h tag=%0d src=%0d inv=%0d, want res=%h tag=%0d src=%0d inv=%0d",
                     out_res, out_tag, out_src, out_inv, e.res, e.tag, e.src, e.inv);
          else
            sb_pass++;
        end
        log_q.push_back({out_src, out_tag});
      end
      if (req_rdy != 2'b00) begin
        sb_chk++;
        if ((req_rdy & ~req_vld) != 2'b00 || req_rdy == 2'b11)
          $display("FAIL sb_rdy_onehot: req_rdy=%b req_vld=%b", req_rdy, req_vld);
        else
          sb_pass++;
      end
      if (flush) sb_q.delete();
      for (int i = 0; i < 2; i++) begin
        if (req_vld[i] && req_rdy[i]) begin
          e.res = ref_round(req_A[i], req_rbit[i], req_tail[i], req_rndbit[i],
                            req_rmode[i], req_fmt_in[i], req_fmt_out[i]);
          e.tag = req_tag[i];
          e.src = 1'(i);
          e.inv = (req_fmt_in[i] == 2'd3) || (req_fmt_out[i] == 2'd3);
          sb_q.push_back(e);
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    set_req(0, 1);
    set_req(1, 2);
    req_vld = 2'b11;
    step();
    step();
    t_chk++; if (out_vld !== 1'b0) $display("FAIL rst_vld: got %b want 0", out_vld); else t_pass++;
    t_chk++; if (out_res !== 80'd0) $display("FAIL rst_res: got %h want 0", out_res); else t_pass++;
    t_chk++; if (out_tag !== '0) $display("FAIL rst_tag: got %0d want 0", out_tag); else t_pass++;
    t_chk++; if (out_src !== 1'b0 || out_inv !== 1'b0)
      $display("FAIL rst_src_inv: got %b%b want 00", out_src, out_inv); else t_pass++;
    t_chk++; if (req_rdy !== 2'b00) $display("FAIL rst_rdy: got %b want 00", req_rdy); else t_pass++;
    req_vld = 2'b00;
    rst_n   = 1'b1;
  endtask

  task automatic test_contention();
    int        n0 = 0;
    int        n1 = 0;
    bit        ok;
    logic [1:0] want;
    logic [9:0] exp_log[4];
    exp_log = '{{1'b0, 9'd1}, {1'b1, 9'd11}, {1'b0, 9'd2}, {1'b1, 9'd12}};
    log_q.delete();
    for (int k = 0; k < 4; k++) begin
      step();
      set_req(0, 1 + n0);
      set_req(1, 11 + n1);
      req_vld = 2'b11;
      #1;
      want = (k % 2 == 0) ? 2'b01 : 2'b10;
      t_chk++; if (req_rdy !== want) $display("FAIL cont_grant%0d: got %b want %b", k, req_rdy, want); else t_pass++;
      if (want[0]) n0++; else n1++;
    end
    step();
    req_vld = 2'b00;
    drain(ok);
    t_chk++; if (!ok) $display("FAIL cont_drain: got busy want idle"); else t_pass++;
    t_chk++; if (log_q.size() != 4) $display("FAIL cont_count: got %0d want 4", log_q.size()); else t_pass++;
    for (int k = 0; k < 4 && k < log_q.size(); k++) begin
      t_chk++;
      if (log_q[k] !== exp_log[k])
        $display("FAIL cont_order%0d: got src/tag %h want %h", k, log_q[k], exp_log[k]);
      else t_pass++;
    end
  endtask

  // Drives one op from req0 and checks its fixed two-cycle arrival.
  task automatic run_one(string nm, logic [80:0] a, logic rb, logic tl, logic lb,
                         logic [1:0] fi, logic [1:0] fo, int tag,
                         logic [79:0] want_res, logic want_inv);
    step();
    set_req(0, tag);
    req_A[0] = a; req_rbit[0] = rb; req_tail[0] = tl; req_rndbit[0] = lb;
    req_rmode[0] = 3'd0; req_fmt_in[0] = fi; req_fmt_out[0] = fo;
    req_vld = 2'b01;
    #1;
    t_chk++; if (req_rdy !== 2'b01) $display("FAIL %s_rdy: got %b want 01", nm, req_rdy); else t_pass++;
    step();
    req_vld = 2'b00;
    #1;
    t_chk++; if (out_vld !== 1'b0) $display("FAIL %s_early: got out_vld=%b want 0", nm, out_vld); else t_pass++;
    step();
    #1;
    t_chk++; if (out_vld !== 1'b1 || out_tag !== TW'(tag) || out_src !== 1'b0)
      $display("FAIL %s_out: got vld=%b tag=%0d src=%b want 1/%0d/0", nm, out_vld, out_tag, out_src, tag);
    else t_pass++;
    t_chk++; if (out_res !== want_res || out_inv !== want_inv)
      $display("FAIL %s_res: got %h inv=%b want %h inv=%b", nm, out_res, out_inv, want_res, want_inv);
    else t_pass++;
    step();
    #1;
    t_chk++; if (out_vld !== 1'b0) $display("FAIL %s_once: got out_vld=%b want 0", nm, out_vld); else t_pass++;
  endtask

  task automatic test_single();
    run_one("single", 81'h0_3FF0_0000_0000_0001, 1'b0, 1'b0, 1'b0, 2'd1, 2'd1, 5,
            80'h0000_3FF0_0000_0000_0000, 1'b0);
  endtask

  task automatic test_round_carry();
    run_one("carry", {1'b0, 15'h3FFF, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF}, 1'b1, 1'b0, 1'b1,
            2'd2, 2'd2, 6, 80'h4000_8000_0000_0000_0000, 1'b0);
  endtask

  task automatic test_illegal();
    run_one("illegal", 81'h0_1234_5678_9ABC_DEF0, 1'b1, 1'b1, 1'b1, 2'd1, 2'd3, 7,
            80'h7FFF_C000_0000_0000_0000, 1'b1);
  endtask

  task automatic test_backpressure();
    int n = 0;
    bit ok;
    log_q.delete();
    for (int k = 0; k < 12; k++) begin
      step();
      out_rdy = !(k >= 3 && k <= 6);
      if (n < 5) begin
        set_req(1, 21 + n);
        req_vld = 2'b10;
      end else begin
        req_vld = 2'b00;
      end
      #1;
      if (k == 4) begin
        t_chk++; if (req_rdy !== 2'b00) $display("FAIL bp_rdy_drop: got %b want 00", req_rdy); else t_pass++;
      end
      if (k == 7) begin
        t_chk++; if (req_rdy !== 2'b10) $display("FAIL bp_resume: got %b want 10", req_rdy); else t_pass++;
      end
      if (k >= 4 && k <= 6) begin
        t_chk++;
        if (out_vld !== 1'b1 || out_tag !== TW'(22) || out_res !== ref_tag(22))
          $display("FAIL bp_hold%0d: got vld=%b tag=%0d res=%h want 1/22/%h", k, out_vld, out_tag, out_res, ref_tag(22));
        else t_pass++;
      end
      if (req_rdy[1]) n++;
    end
    out_rdy = 1'b1;
    req_vld = 2'b00;
    drain(ok);
    t_chk++; if (!ok) $display("FAIL bp_drain: got busy want idle"); else t_pass++;
    t_chk++; if (log_q.size() != 5) $display("FAIL bp_count: got %0d want 5", log_q.size()); else t_pass++;
    for (int k = 0; k < 5 && k < log_q.size(); k++) begin
      t_chk++;
      if (log_q[k] !== {1'b1, 9'(21 + k)})
        $display("FAIL bp_order%0d: got %h want %h", k, log_q[k], {1'b1, 9'(21 + k)});
      else t_pass++;
    end
  endtask

  task automatic test_flush();
    bit ok;
    log_q.delete();
    out_rdy = 1'b1;
    step(); set_req(1, 31); req_vld = 2'b10;
    step(); set_req(1, 32); req_vld = 2'b10;
    step(); flush = 1'b1; set_req(0, 33); req_vld = 2'b01;
    #1;
    t_chk++; if (req_rdy !== 2'b00) $display("FAIL flush_rdy: got %b want 00", req_rdy); else t_pass++;
    t_chk++; if (out_vld !== 1'b1 || out_tag !== TW'(31))
      $display("FAIL flush_head: got vld=%b tag=%0d want 1/31", out_vld, out_tag); else t_pass++;
    step(); flush = 1'b0;
    #1;
    t_chk++; if (out_vld !== 1'b0) $display("FAIL flush_kill: got %b want 0", out_vld); else t_pass++;
    t_chk++; if (req_rdy !== 2'b01) $display("FAIL flush_accept: got %b want 01", req_rdy); else t_pass++;
    step(); req_vld = 2'b00;
    #1;
    t_chk++; if (out_vld !== 1'b0) $display("FAIL flush_gap: got %b want 0", out_vld); else t_pass++;
    step();
    #1;
    t_chk++; if (out_vld !== 1'b1 || out_tag !== TW'(33) || out_src !== 1'b0)
      $display("FAIL flush_next: got vld=%b tag=%0d src=%b want 1/33/0", out_vld, out_tag, out_src);
    else t_pass++;
    drain(ok);
    t_chk++; if (!ok || log_q.size() != 2) $display("FAIL flush_count: got %0d want 2", log_q.size()); else t_pass++;
    if (log_q.size() == 2) begin
      t_chk++;
      if (log_q[0] !== {1'b1, 9'd31} || log_q[1] !== {1'b0, 9'd33})
        $display("FAIL flush_order: got %h,%h want 21f,021", log_q[0], log_q[1]);
      else t_pass++;
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    log_q.delete();
    out_rdy = 1'b0;
    step(); set_req(0, 41); req_vld = 2'b01;
    step(); set_req(0, 43); req_vld = 2'b01;
    step(); req_vld = 2'b00; rst_n = 1'b0;
    #1;
    t_chk++; if (out_vld !== 1'b1) $display("FAIL rmid_loaded: got %b want 1", out_vld); else t_pass++;
    step();
    #1;
    t_chk++; if (out_vld !== 1'b0 || out_tag !== '0)
      $display("FAIL rmid_clear: got vld=%b tag=%0d want 0/0", out_vld, out_tag); else t_pass++;
    rst_n   = 1'b1;
    out_rdy = 1'b1;
    step(); set_req(0, 51); set_req(1, 52); req_vld = 2'b11;
    #1;
    t_chk++; if (req_rdy !== 2'b01) $display("FAIL rmid_ptr: got %b want 01", req_rdy); else t_pass++;
    step(); req_vld = 2'b00;
    drain(ok);
    t_chk++; if (!ok || log_q.size() != 1) $display("FAIL rmid_count: got %0d want 1", log_q.size()); else t_pass++;
    if (log_q.size() == 1) begin
      t_chk++; if (log_q[0] !== {1'b0, 9'd51}) $display("FAIL rmid_first: got %h want 033", log_q[0]); else t_pass++;
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; req_vld = 2'b00; out_rdy = 1'b1;
    req_A = '0; req_rbit = '0; req_tail = '0; req_rndbit = '0;
    req_rmode = '0; req_fmt_in = '0; req_fmt_out = '0; req_tag = '0;
    test_reset();
    test_contention();
    test_single();
    test_round_carry();
    test_illegal();
    test_backpressure();
    test_flush();
    test_reset_mid();
    step();
    $display("%0d/%0d checks passed", t_pass + sb_pass, t_chk + sb_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
